addr_sweep_gen: RTL and testbench

Parametrised address-sweep generator for the draw path. On a start pulse it emits LANES interleaved addresses per beat, walking a programmable range. Each beat is offered over a valid/ready handshake so a frame-buffer writer can stall it. Supersedes fixed-range, fixed two-lane, free-running address counters with a runtime-programmable, backpressure-aware, restartable sweep.

---
 rtl/addr_sweep_gen.sv | 102 ++++++++++
 tb/tb_addr_sweep_gen.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/addr_sweep_gen.sv
// addr_sweep_gen: restartable LANES-wide address sweep over valid/ready; SWEEP_LOOP_EN adds loop_en for continuous wrap.
module addr_sweep_gen #(
  parameter int ADDR_W = 14,
  parameter int LANES  = 2,
  parameter int CNT_W  = 14
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base,
  input  logic [CNT_W-1:0]        count,
  input  logic                    ready,
`ifdef SWEEP_LOOP_EN
  input  logic                    loop_en,
`endif
  output logic                    valid,
  output logic [LANES*ADDR_W-1:0] addr,
  output logic                    last,
  output logic                    busy,
  output logic                    done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       ab_q, ab_d, a0;
  logic [CNT_W-1:0]        cnt_q, cnt_d, b_q, b_d;
  logic [LANES*ADDR_W-1:0] addr_q, addr_d;
  logic                    valid_q, valid_d, last_q, last_d, busy_q, busy_d, done_q, done_d;
  logic                    load, wrap;
`ifdef SWEEP_LOOP_EN
  assign wrap = loop_en;
`else
  assign wrap = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    ab_d    = ab_q;
    cnt_d   = cnt_q;
    b_d     = b_q;
    valid_d = valid_q;
    last_d  = last_q;
    done_d  = 1'b0;
    load    = 1'b0;
    a0      = ab_q;
    case (state_q)
      IDLE: if (start) begin
        ab_d    = base & ~ADDR_W'(LANES - 1);
        cnt_d   = count;
        b_d     = '0;
        a0      = ab_d;
        load    = count != '0;
        valid_d = load;
        last_d  = count == CNT_W'(1);
        done_d  = !load;
        state_d = load ? RUN : DONE;
      end
      RUN: if (valid_q && ready) begin
        // lane 0 steps by LANES per beat; a wrap reloads it from the latched base
        load    = !last_q || wrap;
        b_d     = last_q ? '0 : b_q + CNT_W'(1);
        a0      = last_q ? ab_q : addr_q[ADDR_W-1:0] + ADDR_W'(LANES);
        last_d  = last_q ? (wrap && cnt_q == CNT_W'(1)) : (b_q + CNT_W'(2) == cnt_q);
        valid_d = !last_q || wrap;
        done_d  = last_q;
        state_d = (last_q && !wrap) ? DONE : RUN;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    addr_d = addr_q;
    for (int k = 0; k < LANES; k++)
      if (load) addr_d[k*ADDR_W +: ADDR_W] = a0 + ADDR_W'(k);
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ab_q    <= '0;
      cnt_q   <= '0;
      b_q     <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ab_q    <= ab_d;
      cnt_q   <= cnt_d;
      b_q     <= b_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign valid = valid_q;
  assign addr  = addr_q;
  assign last  = last_q;
  assign busy  = busy_q;
  assign done  = done_q;
endmodule

// File: tb/tb_addr_sweep_gen.sv
// tb_addr_sweep_gen: scoreboard bench; expected beats come from a plain arithmetic sweep model.
module tb_addr_sweep_gen;
  localparam int AW = 14, L = 2, CW = 14;
  logic clk = 0, reset = 0, start = 0, ready = 0;
  logic [AW-1:0] base = '0;
  logic [CW-1:0] count = '0;
  logic valid, last, busy, done;
  logic [L*AW-1:0] addr;
`ifdef SWEEP_LOOP_EN
  logic loop_en = 1'b0;
`endif
  addr_sweep_gen #(.ADDR_W(AW), .LANES(L), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .base(base), .count(count), .ready(ready),
`ifdef SWEEP_LOOP_EN
    .loop_en(loop_en),
`endif
    .valid(valid), .addr(addr), .last(last), .busy(busy), .done(done));
  always #5 clk = ~clk;
  typedef struct packed {logic [L*AW-1:0] a; logic l;} beat_t;
  beat_t q[$];
  int checks = 0, errors = 0, rmode = 0, ph = 0, beats = 0, done_cnt = 0, exp_done = 0;
  bit pend_done = 0, zero_start = 0;
  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", n, act, exp);
    end
  endtask
  function automatic beat_t model(int b0, int cnt, int i);
    beat_t e;
    int ab = b0 - (b0 % L);
    for (int k = 0; k < L; k++) e.a[k*AW +: AW] = AW'((ab + i * L + k) % (1 << AW));
    e.l = (i == cnt - 1);
    return e;
  endfunction
  task automatic do_sweep(input int b0, input int c);
    @(posedge clk); #1;
    base = AW'(b0); count = CW'(c); start = 1;
    for (int i = 0; i < c; i++) q.push_back(model(b0, c, i));
    exp_done++;
    @(posedge clk); #1;
    start = 0; base = AW'($urandom); count = CW'($urandom);
    chk("valid_latency", valid, c != 0);
    chk("busy_at_start", busy, 1);
    chk("done_at_start", done, c == 0);
    if (c == 0) zero_start = 1;
  endtask
  task automatic wait_idle(input int lim, output int n);
    n = 0;
    while (n < lim) begin
      @(posedge clk); #1;
      if (!busy) break;
      n++;
    end
    if (busy) begin
      checks++; errors++;
      $display("FAIL sweep_timeout busy=1 expected=0");
    end
    @(negedge clk); #1;
    chk("queue_drained", q.size(), 0);
    chk("done_count", done_cnt, exp_done);
  endtask
  initial forever begin
    @(posedge clk); #1;
    if (rmode == 0) ready = 1;
    else if (rmode == 1) begin ready = (ph % 4 == 0) || (ph % 4 == 3); ph++; end
    else ready = 1'($urandom_range(0, 1));
  end
  initial begin : monitor
    bit held = 0;
    logic [L*AW-1:0] hold_a;
    logic hold_l;
    beat_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        held = 0; pend_done = 0; zero_start = 0;
      end else begin
        if (pend_done || zero_start || done) chk("done_pulse", done, pend_done || zero_start);
        if (done) done_cnt++;
        pend_done = 0; zero_start = 0;
        if (held) begin
          chk("stall_valid", valid, 1);
          chk("stall_addr", addr, hold_a);
          chk("stall_last", last, hold_l);
        end
        if (valid && ready) begin
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_beat addr=%0h expected=none", addr);
          end else begin
            e = q.pop_front();
            chk("addr", addr, e.a);
            chk("last", last, e.l);
            pend_done = e.l;
            beats++;
          end
          held = 0;
        end else if (valid) begin
          held = 1; hold_a = addr; hold_l = last;
        end else held = 0;
      end
    end
  end
  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    int n, b0;
    #1;
    chk("rst_valid", valid, 0); chk("rst_addr", addr, 0); chk("rst_last", last, 0);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    #20 @(negedge clk) reset = 1;
    rmode = 0; do_sweep(6144, 64); wait_idle(200, n);
    rmode = 1; ph = 0; do_sweep(6144, 64); wait_idle(400, n);
    rmode = 0; do_sweep(1234, 0); wait_idle(10, n);
    chk("zero_busy_cycles", n, 0);
    do_sweep(16380, 4); wait_idle(50, n);
    do_sweep(6145, 2);
    base = 100; count = 3; start = 1;
    @(posedge clk); #1 start = 0;
    wait_idle(50, n);
    do_sweep(500, 1);
    @(posedge clk); #1 base = 700; count = 5; start = 1;
    @(posedge clk); #1 start = 0;
    chk("start_in_done_busy", busy, 0);
    wait_idle(20, n);
    b0 = beats;
    do_sweep(6144, 64);
    for (int i = 0; i < 200 && beats - b0 < 10; i++) begin @(negedge clk); #1; end
    @(posedge clk); #2 reset = 0;
    #1;
    chk("abort_valid", valid, 0); chk("abort_addr", addr, 0);
    chk("abort_busy", busy, 0); chk("abort_done", done, 0);
    chk("beats_before_reset", beats - b0, 10);
    q.delete(); exp_done--;
    repeat (3) @(posedge clk);
    #3 reset = 1;
    do_sweep(3001, 5); wait_idle(50, n);
    rmode = 2;
    for (int t = 0; t < 10; t++) begin
      do_sweep(int'($urandom_range(0, (1 << AW) - 1)), (t == 4) ? 0 : int'($urandom_range(1, 20)));
      wait_idle(200, n);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
